// File: rtl/sine_wave_reader.sv
// ---------------------------------------------------------------------------
// sine_wave_reader
//
// Walks a rising half-sine table up to its peak and back down to produce a
// continuous full-period sample stream. Each sample is offered on a
// valid/ready interface. A programmable divider sets the spacing between
// sample issues.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   enable        run request (level)
//   divider       cycles between issues minus 1, sampled at each issue
//   table_size    last valid table index, latched when leaving IDLE
//   table_addr    index presented to the external combinational table
//   table_data    table entry at table_addr
//   sample        registered output sample
//   out_valid     sample holds valid data
//   out_ready     consumer accepts on out_valid && out_ready
//   period_start  sample is index 0 of a rising sweep (valid with out_valid)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | stopped; waits for enable, latches table_size
// RISE  | index walks 0 .. last
// FALL  | index walks last-1 .. 1
// ---------------------------------------------------------------------------
module sine_wave_reader #(
    parameter int SINE_SIZE      = 8,
    parameter int TABLE_SIZE     = 32,
    parameter int TABLE_REG_SIZE = 6,
    parameter int DIV_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [DIV_WIDTH-1:0]      divider,
    input  logic [TABLE_REG_SIZE-1:0] table_size,
    output logic [TABLE_REG_SIZE-2:0] table_addr,
    input  logic [SINE_SIZE-1:0]      table_data,
    output logic [SINE_SIZE-1:0]      sample,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      period_start
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_t;

    localparam logic [TABLE_REG_SIZE-1:0] MAX_IDX = TABLE_REG_SIZE'(TABLE_SIZE - 1);
    localparam logic [TABLE_REG_SIZE-1:0] ONE_IDX = TABLE_REG_SIZE'(1);
    localparam logic [TABLE_REG_SIZE-1:0] TWO_IDX = TABLE_REG_SIZE'(2);

    state_t                    state;
    logic [TABLE_REG_SIZE-1:0] idx;
    logic [TABLE_REG_SIZE-1:0] last;
    logic [DIV_WIDTH-1:0]      cnt;

    logic                      accept;
    logic                      slot_free;
    logic [TABLE_REG_SIZE-1:0] last_clamped;
    logic [TABLE_REG_SIZE-1:0] adv_idx;
    state_t                    adv_state;

    assign table_addr = idx[TABLE_REG_SIZE-2:0];

    assign accept    = out_valid && out_ready;
    // The output register can take a new sample when it is empty or when
    // the current one is being consumed on this same edge.
    assign slot_free = !out_valid || out_ready;

    // A table_size past the end of the table would alias onto low entries
    // through the narrower table address, so it is clipped to the last entry.
    assign last_clamped = (table_size > MAX_IDX) ? MAX_IDX : table_size;

    // Index walk after an issue. The peak and the zero are each visited once
    // per period: the falling leg stops at 1 and the rising leg restarts at 0.
    // With last <= 1 there is no falling leg at all, so the peak wraps
    // straight back to 0 (last=1 gives 0,1,0,1..., last=0 stays at 0).
    always_comb begin
        adv_idx   = idx;
        adv_state = state;
        case (state)
            RISE: begin
                if (idx < last) begin
                    adv_idx = idx + ONE_IDX;
                end else if (last >= TWO_IDX) begin
                    adv_idx   = last - ONE_IDX;
                    adv_state = FALL;
                end else begin
                    adv_idx   = '0;
                    adv_state = RISE;
                end
            end
            FALL: begin
                if (idx > ONE_IDX) begin
                    adv_idx = idx - ONE_IDX;
                end else begin
                    adv_idx   = '0;
                    adv_state = RISE;
                end
            end
            default: begin
                adv_idx   = idx;
                adv_state = state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            last         <= '0;
            cnt          <= '0;
            sample       <= '0;
            out_valid    <= 1'b0;
            period_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RISE;
                        idx   <= '0;
                        cnt   <= divider;
                        last  <= last_clamped;
                    end
                end

                RISE, FALL: begin
                    if (!enable) begin
                        // Stop issuing; leave only once any pending sample
                        // has been taken so it is never lost.
                        if (slot_free) begin
                            state        <= IDLE;
                            idx          <= '0;
                            out_valid    <= 1'b0;
                            period_start <= 1'b0;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - DIV_WIDTH'(1);
                        if (accept) begin
                            out_valid    <= 1'b0;
                            period_start <= 1'b0;
                        end
                    end else if (slot_free) begin
                        sample       <= table_data;
                        out_valid    <= 1'b1;
                        period_start <= (state == RISE) && (idx == '0);
                        cnt          <= divider;
                        idx          <= adv_idx;
                        state        <= adv_state;
                    end
                    // Otherwise stalled: cnt holds at 0 and the sample waits.
                end

                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sine_wave_reader.sv
module tb_sine_wave_reader;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [15:0] divider;
    logic [5:0] table_size;
    logic [4:0] table_addr;
    logic [7:0] table_data;
    logic [7:0] sample;
    logic       out_valid;
    logic       out_ready;
    logic       period_start;

    sine_wave_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .divider      (divider),
        .table_size   (table_size),
        .table_addr   (table_addr),
        .table_data   (table_data),
        .sample       (sample),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .period_start (period_start)
    );

    // Rising half-sine stand-in: strictly increasing random entries from 0.
    logic [7:0] tbl [0:31];
    assign table_data = tbl[table_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    bit hs    = 0;

    // Reference: the index sequence of one period, and the position of the
    // next sample the consumer should receive.
    int seq[$];
    int pos = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void build_seq(input int l);
        seq.delete();
        for (int i = 0; i <= l; i++) seq.push_back(i);
        for (int i = l - 1; i >= 1; i--) seq.push_back(i);
        pos = 0;
    endfunction

    // One clock: handshakes at the edge are scored against the reference;
    // a sample that was held (valid, not ready) must still be there after.
    task automatic cyc();
        logic       pv, pr, pp;
        logic [7:0] psmp;
        pv   = out_valid;
        pr   = out_ready;
        psmp = sample;
        pp   = period_start;
        @(posedge clk);
        #1;
        cyc_n++;
        hs = pv && pr;
        if (pv && pr) begin
            if (seq.size() == 0) begin
                chk("hs_unexpected", 32'(pv), 32'd0);
            end else begin
                chk("hs_sample", 32'(psmp), 32'(tbl[seq[pos]]));
                chk("hs_pstart", 32'(pp), 32'(pos == 0));
                pos = (pos + 1) % seq.size();
            end
        end else if (pv) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sample", 32'(sample), 32'(psmp));
            chk("hold_pstart", 32'(period_start), 32'(pp));
        end
    endtask

    task automatic start_run(input int d, input int l);
        divider    = 16'(d);
        table_size = 6'(l);
        enable     = 1'b1;
        build_seq(l);
    endtask

    task automatic stop_run();
        enable    = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("stop_idle", 32'(out_valid), 32'd0);
    endtask

    task automatic run_div(input int d);
        int n0, first, last_hs, count;
        start_run(d, 31);
        out_ready = 1'b1;
        cyc();
        n0    = cyc_n;
        first = -1;
        for (int k = 0; k < d + 10; k++) begin
            cyc();
            if (out_valid) begin
                first = cyc_n - n0;
                break;
            end
        end
        chk("first_latency", 32'(first), 32'(d + 1));
        last_hs = -1;
        count   = 0;
        for (int k = 0; k < 10 * (d + 1) + 20; k++) begin
            cyc();
            if (hs) begin
                if (last_hs >= 0) chk("issue_gap", 32'(cyc_n - last_hs), 32'(d + 1));
                last_hs = cyc_n;
                count++;
                if (count == 6) break;
            end
        end
        chk("gap_count", 32'(count), 32'd6);
        stop_run();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_at;
        logic [7:0] held;

        tbl[0] = 8'd0;
        for (int i = 1; i < 32; i++) tbl[i] = tbl[i-1] + 8'($urandom_range(1, 7));

        rst_n      = 1'b0;
        enable     = 1'b0;
        divider    = 16'd0;
        table_size = 6'd31;
        out_ready  = 1'b1;

        // Reset values with the clock running.
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pstart", 32'(period_start), 32'd0);
        chk("rst_addr", 32'(table_addr), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("idle_valid", 32'(out_valid), 32'd0);
            chk("idle_sample", 32'(sample), 32'd0);
        end

        // Full period, divider 0, with a backpressure window mid-rise.
        start_run(0, 31);
        cyc();
        chk("ov_after_e0", 32'(out_valid), 32'd0);
        cyc();
        chk("ov_after_e1", 32'(out_valid), 32'd1);
        for (int k = 0; k < 130; k++) begin
            cyc();
            chk("no_gap", 32'(out_valid), 32'd1);
        end
        stall_at = $urandom_range(5, 25);
        for (int k = 0; k < 100 && pos != stall_at; k++) cyc();
        chk("bp_reach", 32'(pos), 32'(stall_at));
        out_ready = 1'b0;
        held = tbl[seq[pos]];
        chk("bp_pre", 32'(sample), 32'(held));
        for (int k = 0; k < 10; k++) cyc();
        chk("bp_held", 32'(sample), 32'(held));
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) cyc();

        // Disable with an unaccepted sample pending.
        out_ready = 1'b0;
        cyc();
        held = sample;
        enable = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        chk("dis_pending", 32'(out_valid), 32'd1);
        chk("dis_held", 32'(sample), 32'(held));
        out_ready = 1'b1;
        cyc();
        chk("dis_idle", 32'(out_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("dis_stay_idle", 32'(out_valid), 32'd0);
        end
        start_run(0, 31);
        for (int k = 0; k < 70; k++) cyc();
        stop_run();

        // Divider spacing and first-sample latency.
        run_div(3);
        run_div($urandom_range(0, 6));
        run_div($urandom_range(1, 9));

        // Random backpressure against the reference.
        start_run($urandom_range(0, 3), 31);
        for (int k = 0; k < 300; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        stop_run();

        // last = 0: constant table[0], every sample a period start.
        start_run($urandom_range(0, 2), 0);
        for (int k = 0; k < 20; k++) cyc();
        stop_run();

        // last = 1: alternating; a mid-run table_size change is ignored.
        start_run(1, 1);
        for (int k = 0; k < 12; k++) cyc();
        table_size = 6'd31;
        for (int k = 0; k < 12; k++) cyc();
        stop_run();

        // Asynchronous reset in the falling leg.
        start_run(0, 31);
        for (int k = 0; k < 200 && pos != 40; k++) cyc();
        chk("fall_reach", 32'(pos), 32'd40);
        chk("fall_nonzero", 32'(sample != 8'd0), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_sample", 32'(sample), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pstart", 32'(period_start), 32'd0);
        chk("arst_addr", 32'(table_addr), 32'd0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        chk("post_rst_idle", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
